// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake between the pipeline and the iterative RV32M multiply/divide sequencer.
// The master is the EX/hazard side and the slave is the sequencer.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            StartE;
  logic [2:0]      Funct3E;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            KillE;
  logic            StallReqE;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] ResultE;

  modport master (
    output StartE, Funct3E, SrcAE, SrcBE, KillE,
    input  StallReqE, Busy, Done, ResultE
  );

  modport slave (
    input  StartE, Funct3E, SrcAE, SrcBE, KillE,
    output StallReqE, Busy, Done, ResultE
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: one 64-bit shift/add-subtract step per cycle,
// 32 steps per operation, with a one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_sequencer (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t      state, state_d;
  logic [2:0]  op, op_d;
  logic [31:0] opb, opb_d;          // multiplicand or divisor magnitude
  logic [63:0] acc, acc_d;          // {hi, lo}: product, or {remainder, quotient}
  logic [4:0]  cnt, cnt_d;
  logic        neg_a, neg_a_d;
  logic        neg_b, neg_b_d;
  logic [31:0] result, result_d;

  // Operand conditioning straight from the EX inputs.
  logic        in_div, sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic [31:0] mag_a, mag_b;
  logic        fast_div0, fast_ovf;
  logic [31:0] fast_result;

  assign in_div    = bus.Funct3E[2];
  assign sgn_a     = in_div ? ~bus.Funct3E[0] : (bus.Funct3E != 3'b011);
  assign sgn_b     = in_div ? ~bus.Funct3E[0] : ~bus.Funct3E[1];
  assign in_neg_a  = sgn_a & bus.SrcAE[31];
  assign in_neg_b  = sgn_b & bus.SrcBE[31];
  assign mag_a     = in_neg_a ? -bus.SrcAE : bus.SrcAE;
  assign mag_b     = in_neg_b ? -bus.SrcBE : bus.SrcBE;
  assign fast_div0 = in_div & (bus.SrcBE == 32'h0);
  assign fast_ovf  = in_div & ~bus.Funct3E[0] & (bus.SrcAE == 32'h8000_0000)
                   & (bus.SrcBE == 32'hFFFF_FFFF);
  assign fast_result = bus.Funct3E[1] ? (fast_div0 ? bus.SrcAE : 32'h0)
                                      : (fast_div0 ? 32'hFFFF_FFFF : 32'h8000_0000);

  // Shared step: shift-add (LSB first) for multiply, restoring subtract (MSB first) for divide.
  logic [32:0] mul_sum, div_diff;
  logic [63:0] mul_next, div_next, step;

  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'h0);
  assign mul_next = {mul_sum, acc[31:1]};
  assign div_diff = acc[63:31] - {1'b0, opb};
  // A clear borrow bit means the shifted partial remainder covered the divisor.
  assign div_next = div_diff[32] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
  assign step     = op[2] ? div_next : mul_next;

  // Sign fix and result selection applied to the value of the final step.
  logic [63:0] prod;
  logic [31:0] quo, rem, final_result;

  assign prod = (neg_a ^ neg_b) ? -step : step;
  assign quo  = (neg_a ^ neg_b) ? -step[31:0] : step[31:0];
  assign rem  = neg_a ? -step[63:32] : step[63:32];

  always_comb begin
    case (op)
      3'b000:                 final_result = prod[31:0];
      3'b001, 3'b010, 3'b011: final_result = prod[63:32];
      3'b100, 3'b101:         final_result = quo;
      default:                final_result = rem;
    endcase
  end

  always_comb begin
    // NOTE: every target gets its hold value first so no path leaves one unassigned (no latches).
    state_d  = state;
    op_d     = op;
    opb_d    = opb;
    acc_d    = acc;
    cnt_d    = cnt;
    neg_a_d  = neg_a;
    neg_b_d  = neg_b;
    result_d = result;

    if (bus.KillE) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.StartE) begin
            op_d    = bus.Funct3E;
            opb_d   = mag_b;
            acc_d   = {32'h0, mag_a};
            cnt_d   = 5'd0;
            neg_a_d = in_neg_a;
            neg_b_d = in_neg_b;
            if (fast_div0 || fast_ovf) begin
              state_d  = DONE;
              result_d = fast_result;
            end else begin
              state_d = ITER;
            end
          end
        end
        ITER: begin
          acc_d = step;
          cnt_d = cnt + 5'd1;
          if (cnt == 5'd31) begin
            state_d  = DONE;
            result_d = final_result;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are cleared too; the block is small and a known state eases debug.
      state  <= IDLE;
      op     <= 3'b000;
      opb    <= 32'h0;
      acc    <= 64'h0;
      cnt    <= 5'd0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      result <= 32'h0;
    end else begin
      state  <= state_d;
      op     <= op_d;
      opb    <= opb_d;
      acc    <= acc_d;
      cnt    <= cnt_d;
      neg_a  <= neg_a_d;
      neg_b  <= neg_b_d;
      result <= result_d;
    end
  end

  assign bus.Busy      = (state == ITER);
  assign bus.Done      = (state == DONE);
  assign bus.ResultE   = result;
  assign bus.StallReqE = bus.StartE & ~bus.Done & ~bus.KillE & ~rst;
endmodule
